// File: rtl/pll_lock_sequencer.sv
// PLL power-up and lock-loss sequencer running on the reference clock.
// Define PLL_SEQ_TIMEOUT_EN to pulse the PLL reset when lock never arrives.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES = 8,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       locked,
  output logic       pll_resetb,
  output logic       clk_en,
  output logic       core_resetn,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    CLK_ON,
    RUN,
    LOST
`ifdef PLL_SEQ_TIMEOUT_EN
    , PLL_RST
`endif
  } state_t;

  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || PLL_RST_CYCLES < 1 ||
      CNT_W < 1 || CNT_W > 30 ||
      STABLE_CYCLES > (1 << CNT_W) ||
      HOLD_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
    $error("pll_lock_sequencer: invalid parameters");
  end

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LD     = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [CNT_W-1:0] WL_LD     = '0;
`endif

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   clk_en_q, clk_en_d;
  logic                   core_resetn_q, core_resetn_d;
  logic                   ready_q, ready_d;
  logic [7:0]             llc_q, llc_d;
  logic                   lock_s;
`ifdef PLL_SEQ_TIMEOUT_EN
  logic                   pll_q, pll_d;
  logic [3:0]             retry_q, retry_d;
  logic                   armed_q, armed_d;
`endif

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], locked};
    state_d       = state_q;
    cnt_d         = cnt_q;
    clk_en_d      = clk_en_q;
    core_resetn_d = core_resetn_q;
    ready_d       = ready_q;
    llc_d         = llc_q;
`ifdef PLL_SEQ_TIMEOUT_EN
    pll_d         = 1'b1;
    retry_d       = retry_q;
    armed_d       = armed_q;
`endif
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = STABLE_LD;
`ifdef PLL_SEQ_TIMEOUT_EN
        end else if (!armed_q) begin
          // first cycle out of reset starts the timeout
          cnt_d   = WL_LD;
          armed_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = PLL_RST;
          cnt_d   = RST_LD;
          pll_d   = 1'b0;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end else begin
          cnt_d = cnt_q - ONE;
`endif
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = WL_LD;
        end else if (cnt_q == '0) begin
          state_d  = CLK_ON;
          cnt_d    = HOLD_LD;
          clk_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      CLK_ON: begin
        if (!lock_s) begin
          state_d       = LOST;
          clk_en_d      = 1'b0;
          core_resetn_d = 1'b0;
          ready_d       = 1'b0;
        end else if (cnt_q == '0) begin
          state_d       = RUN;
          core_resetn_d = 1'b1;
          ready_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d       = LOST;
          clk_en_d      = 1'b0;
          core_resetn_d = 1'b0;
          ready_d       = 1'b0;
          if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end
      end
      LOST: begin
        state_d = WAIT_LOCK;
        cnt_d   = WL_LD;
      end
`ifdef PLL_SEQ_TIMEOUT_EN
      PLL_RST: begin
        if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
          cnt_d   = WL_LD;
        end else begin
          pll_d = 1'b0;
          cnt_d = cnt_q - ONE;
        end
      end
`endif
      default: begin
        state_d       = WAIT_LOCK;
        cnt_d         = WL_LD;
        clk_en_d      = 1'b0;
        core_resetn_d = 1'b0;
        ready_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      sync_q        <= '0;
      clk_en_q      <= 1'b0;
      core_resetn_q <= 1'b0;
      ready_q       <= 1'b0;
      llc_q         <= '0;
`ifdef PLL_SEQ_TIMEOUT_EN
      pll_q         <= 1'b1;
      retry_q       <= '0;
      armed_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync_q        <= sync_d;
      clk_en_q      <= clk_en_d;
      core_resetn_q <= core_resetn_d;
      ready_q       <= ready_d;
      llc_q         <= llc_d;
`ifdef PLL_SEQ_TIMEOUT_EN
      pll_q         <= pll_d;
      retry_q       <= retry_d;
      armed_q       <= armed_d;
`endif
    end
  end

  assign clk_en          = clk_en_q;
  assign core_resetn     = core_resetn_q;
  assign ready           = ready_q;
  assign lock_loss_count = llc_q;
`ifdef PLL_SEQ_TIMEOUT_EN
  assign pll_resetb      = pll_q;
  assign retry_count     = retry_q;
`else
  assign pll_resetb      = 1'b1;
  assign retry_count     = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expected output changes are
// queued with their edge number and matched by a negedge monitor.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       locked;
  logic       pll_resetb;
  logic       clk_en;
  logic       core_resetn;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [3:0] retry_count;

  pll_lock_sequencer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (4),
    .TIMEOUT_CYCLES(32),
    .PLL_RST_CYCLES(3),
    .CNT_W         (17)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .locked         (locked),
    .pll_resetb     (pll_resetb),
    .clk_en         (clk_en),
    .core_resetn    (core_resetn),
    .ready          (ready),
    .lock_loss_count(lock_loss_count),
    .retry_count    (retry_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic       m_pll, m_clk, m_core, m_rdy;
  logic [7:0] m_llc;
  logic [3:0] m_retry;
  logic [15:0] m_last;

  function automatic logic [15:0] mvec();
    return {m_pll, m_clk, m_core, m_rdy, m_llc, m_retry};
  endfunction

  task automatic expect_at(input int c, input string nm);
    exp_t e;
    if (mvec() !== m_last) begin
      e.c = c;
      e.v = mvec();
      e.name = nm;
      q.push_back(e);
      m_last = mvec();
    end
  endtask

  // Monitor: any change of the output bundle must match the queue head.
  logic [15:0] prev;
  bit          first = 1'b1;
  always @(negedge clk) begin
    logic [15:0] cur;
    exp_t        e;
    cur = {pll_resetb, clk_en, core_resetn, ready,
           lock_loss_count, retry_count};
    checks++;
    if (core_resetn && !clk_en) begin
      errors++;
      $display("FAIL order cyc=%0d core_resetn=1 with clk_en=0", cyc);
    end
    if (first || cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected cyc=%0d got=%h", cyc, cur);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.v !== cur) begin
          errors++;
          $display("FAIL %s got cyc=%0d val=%h expected cyc=%0d val=%h",
                   e.name, cyc, cur, e.c, e.v);
        end
      end
    end
    first = 1'b0;
    prev  = cur;
  end

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(output int rel);
    resetn  = 1'b0;
    locked  = 1'b0;
    m_pll   = 1'b1;
    m_clk   = 1'b0;
    m_core  = 1'b0;
    m_rdy   = 1'b0;
    m_llc   = '0;
    m_retry = '0;
    expect_at(cyc + 1, "reset");
    nedge(2);
    resetn = 1'b1;
    rel    = cyc + 1;
    nedge(1);
  endtask

  // locked first sampled at edge t: clk_en at t+10, core_resetn at t+14
  task automatic relock(input string nm);
    int t;
    locked = 1'b1;
    t      = cyc + 1;
    m_clk  = 1'b1;
    expect_at(t + 10, {nm, "_clk_en"});
    m_core = 1'b1;
    m_rdy  = 1'b1;
    expect_at(t + 14, {nm, "_core_resetn"});
    nedge(16);
  endtask

  // locked falls between edges; third edge after the fall drops clk_en
  task automatic lose(input string nm);
    int t;
    locked = 1'b0;
    t      = cyc + 1;
    m_clk  = 1'b0;
    m_core = 1'b0;
    m_rdy  = 1'b0;
    if (m_llc != 8'hFF) m_llc = m_llc + 8'd1;
    expect_at(t + 2, nm);
    nedge(4);
  endtask

  initial begin
    int   r, t, t2;
    exp_t e0;
    resetn  = 1'b0;
    locked  = 1'b0;
    m_pll   = 1'b1;
    m_clk   = 1'b0;
    m_core  = 1'b0;
    m_rdy   = 1'b0;
    m_llc   = '0;
    m_retry = '0;
    m_last  = mvec();
    e0.c    = 1;
    e0.v    = mvec();
    e0.name = "reset_state";
    q.push_back(e0);
    nedge(3);
    resetn = 1'b1;
    r      = cyc + 1;

`ifdef PLL_SEQ_TIMEOUT_EN
    begin
      int s;
      s = 0;
      for (int k = 0; k < 17; k++) begin
        s     = r + 32 + 35 * k;
        m_pll = 1'b0;
        if (m_retry != 4'hF) m_retry = m_retry + 4'd1;
        expect_at(s, "pll_rst_lo");
        m_pll = 1'b1;
        expect_at(s + 3, "pll_rst_hi");
      end
      nedge(s + 3 + 10 - cyc);
      relock("timeout_relock");
    end
`else
    nedge(100);
`endif

    // test 1: power-up latency
    do_reset(r);
    relock("powerup");

    // test 2: one-cycle glitch five cycles into STABLE
    do_reset(r);
    locked = 1'b1;
    t      = cyc + 1;
    nedge(5);
    locked = 1'b0;
    nedge(1);
    locked = 1'b1;
    t2     = cyc + 1;
    if (t2 != t + 6) begin
      errors++;
      $display("FAIL glitch_setup t2=%0d need=%0d", t2, t + 6);
    end
    m_clk = 1'b1;
    expect_at(t2 + 10, "glitch_clk_en");
    m_core = 1'b1;
    m_rdy  = 1'b1;
    expect_at(t2 + 14, "glitch_core_resetn");
    nedge(16);

    // test 3: lock loss from RUN and relock
    lose("loss1");
    relock("relock1");

    // test 4: saturation of the loss counter
    for (int i = 0; i < 300; i++) begin
      lose("loss_sat");
      relock("relock_sat");
    end

    // test 5: reset while in CLK_ON
    lose("loss_pre_rst");
    locked = 1'b1;
    t      = cyc + 1;
    m_clk  = 1'b1;
    expect_at(t + 10, "clkon_clk_en");
    nedge(11);
    do_reset(r);
    relock("post_rst");

    nedge(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d expected=0 next=%s",
               q.size(), q[0].name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
